// File: rtl/dispatch_reader.sv
// Consumer side of the dispatch RAM: issues in-order reads, hides the 1-cycle read latency
// with a 2-entry prefetch buffer. Optional stall counter built when DISPATCH_READER_STATS_EN is defined.
module dispatch_reader #(
   parameter int CORE        = 0,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   commit,
   input  logic                   flush,
   output logic                   read,
   output logic [INDEX_WIDTH-1:0] out_address,
   input  logic [DATA_WIDTH-1:0]  out_data,
   output logic                   deq_valid,
   output logic [DATA_WIDTH-1:0]  deq_data,
   input  logic                   deq_ready,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   output logic [31:0]            stall_cycles,
   input  logic                   report
);
   localparam int CW = INDEX_WIDTH + 1;
   localparam logic [CW-1:0] CAP = {1'b1, {INDEX_WIDTH{1'b0}}};

   typedef enum logic {RUN, DRAIN} state_t;

   state_t                 r_state, w_state_nxt;
   logic [INDEX_WIDTH-1:0] r_head, w_head_nxt;
   logic [CW-1:0]          r_pending, w_pending_nxt;
   logic [CW-1:0]          r_outstanding, w_outstanding_nxt;
   logic [DATA_WIDTH-1:0]  r_buf [2];
   logic                   r_rd_ptr, r_wr_ptr;
   logic [1:0]             r_occ;
   logic                   r_in_flight, r_overflow;
   logic                   w_commit_acc, w_land, w_fire, w_bypass, w_pop, w_wr, w_clear;
   logic [1:0]             w_occ_eff;

   assign full         = (r_outstanding == CAP);
   assign empty        = (r_outstanding == '0);
   assign overflow     = r_overflow;
   assign out_address  = r_head;
   assign w_commit_acc = commit & ~full;
   assign w_clear      = flush | (r_state == DRAIN);

   // RAM data landing this cycle; when the buffer is empty it is presented directly so
   // the first entry appears the cycle its read data returns.
   assign w_land    = r_in_flight & (r_state == RUN);
   assign deq_valid = (r_occ != 2'd0) | w_land;
   assign deq_data  = (r_occ != 2'd0) ? r_buf[r_rd_ptr] : out_data;
   assign w_fire    = deq_valid & deq_ready;
   assign w_bypass  = w_fire & (r_occ == 2'd0);
   assign w_pop     = w_fire & (r_occ != 2'd0);
   assign w_wr      = w_land & ~w_bypass & ~w_clear;

   // Occupancy after this cycle's dequeue, so a slot freed now can be refilled now.
   assign w_occ_eff = r_occ + {1'b0, w_land} - {1'b0, w_fire};
   assign read      = (r_state == RUN) & ~flush & (r_pending != '0) & (w_occ_eff < 2'd2);

   always_comb begin
      w_state_nxt       = r_state;
      w_head_nxt        = r_head;
      w_pending_nxt     = r_pending;
      w_outstanding_nxt = r_outstanding;
      case (r_state)
         RUN:     if (flush && r_in_flight) w_state_nxt = DRAIN;
         DRAIN:   w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
      if (w_clear) begin
         w_head_nxt        = r_head + r_pending[INDEX_WIDTH-1:0];
         w_pending_nxt     = '0;
         w_outstanding_nxt = '0;
      end else begin
         w_head_nxt        = r_head + INDEX_WIDTH'(read);
         w_pending_nxt     = r_pending + CW'(w_commit_acc) - CW'(read);
         w_outstanding_nxt = r_outstanding + CW'(w_commit_acc) - CW'(w_fire);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= RUN;
         r_head        <= '0;
         r_pending     <= '0;
         r_outstanding <= '0;
         r_occ         <= '0;
         r_rd_ptr      <= 1'b0;
         r_wr_ptr      <= 1'b0;
         r_in_flight   <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_head        <= w_head_nxt;
         r_pending     <= w_pending_nxt;
         r_outstanding <= w_outstanding_nxt;
         r_in_flight   <= read;
         r_overflow    <= r_overflow | (commit & full);
         if (w_clear) begin
            r_occ    <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
         end else begin
            r_occ <= r_occ + {1'b0, w_wr} - {1'b0, w_pop};
            if (w_wr)  r_wr_ptr <= ~r_wr_ptr;
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_wr) r_buf[r_wr_ptr] <= out_data;
   end

`ifdef DISPATCH_READER_STATS_EN
   logic [31:0] r_stall;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                      r_stall <= '0;
      else if (deq_valid && !deq_ready && r_stall != '1) r_stall <= r_stall + 32'd1;
   end
   assign stall_cycles = r_stall;
`else
   assign stall_cycles = '0;
`endif

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (report)
         $display("dispatch_reader[%0d] head=%0d pending=%0d outstanding=%0d buf_occ=%0d state=%s",
                  CORE, r_head, r_pending, r_outstanding, r_occ, r_state.name());
   end
`endif
endmodule
